simon_round_sequencer: RTL

- Round controller for the Simon-Says game.
- Owns the pattern register bank and grows it by one random colour per round.
- Plays the pattern back to the display/LED stage with timed on/off slots, then collects player button presses and compares each against the stored pattern.
- Updates the score and drives the buzzer on a mismatch or timeout; sits between the LFSR/random source, the button debouncer and the display/buzzer drivers.

---
 rtl/simon_round_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/simon_round_sequencer.sv
// simon_round_sequencer: round controller for the Simon-Says game.
// Holds the pattern bank, appends one random colour per round, plays the
// pattern back with timed on/off slots, then judges the player's presses.
// Optional build macro: SIMON_SPEEDUP_EN -- when defined, the per-colour show
// time shrinks by two ticks per pattern element (floored at four ticks).
module simon_round_sequencer #(
    parameter int MAX_LEN       = 16,
    parameter int COLOR_BITS    = 2,
    parameter int TICK_DIV      = 800000,
    parameter int SHOW_TICKS    = 30,
    parameter int GAP_TICKS     = 10,
    parameter int TIMEOUT_TICKS = 250,
    parameter int BUZZ_TICKS    = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COLOR_BITS-1:0] rnd,
    input  logic                  btn_valid,
    input  logic [COLOR_BITS-1:0] btn_color,
    output logic [COLOR_BITS:0]   disp_color,
    output logic [7:0]            score,
    output logic                  buzzer,
    output logic                  busy,
    output logic                  game_over
);

    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_T0  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int MAX_T1  = (TIMEOUT_TICKS > BUZZ_TICKS) ? TIMEOUT_TICKS : BUZZ_TICKS;
    localparam int MAX_T2  = (MAX_T0 > MAX_T1) ? MAX_T0 : MAX_T1;
    localparam int MAX_T   = (MAX_T2 > 4) ? MAX_T2 : 4;
    localparam int TIMER_W = $clog2(MAX_T + 1);
    localparam int MEM_D   = 2 ** IDX_W;

    localparam logic [COLOR_BITS:0] NULL_COLOR = {1'b1, {COLOR_BITS{1'b0}}};
    localparam logic [LEN_W-1:0]    LEN_MAX    = LEN_W'(MAX_LEN);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXTEND,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_CHECK,
        ST_FAIL,
        ST_WIN
    } state_t;

    state_t                 state_reg, state_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [7:0]             score_reg, score_next;
    logic                   game_over_reg, game_over_next;
    logic [COLOR_BITS:0]    last_press_reg, last_press_next;

    logic [DIV_W-1:0]       div_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic                   tick;
    logic                   timer_restart;
    logic                   timer_clr;
    int                     show_ticks_eff;
    logic                   show_done, gap_done, timeout_done, buzz_done;

    logic [COLOR_BITS-1:0]  pattern_mem [MEM_D];
    logic [COLOR_BITS-1:0]  rd_data_reg;
    logic [IDX_W-1:0]       wr_addr;
    logic                   mem_we;
    logic                   idx_last;

    assign tick     = (div_reg == DIV_LAST);
    assign wr_addr  = len_reg[IDX_W-1:0];
    assign idx_last = ((LEN_W'(idx_reg) + LEN_W'(1)) == len_reg);

    // Effective show time for the current round (shrinks with length when speed-up is built in).
    always_comb begin
        show_ticks_eff = SHOW_TICKS;
`ifdef SIMON_SPEEDUP_EN
        if (SHOW_TICKS - 2 * (int'(len_reg) - 1) > 4)
            show_ticks_eff = SHOW_TICKS - 2 * (int'(len_reg) - 1);
        else
            show_ticks_eff = 4;
`endif
    end

    assign show_done    = tick && (timer_reg == TIMER_W'(show_ticks_eff - 1));
    assign gap_done     = tick && (timer_reg == TIMER_W'(GAP_TICKS - 1));
    assign timeout_done = tick && (timer_reg == TIMER_W'(TIMEOUT_TICKS - 1));
    assign buzz_done    = tick && (timer_reg == TIMER_W'(BUZZ_TICKS - 1));

    // The divider restarts together with the timer so every timed state lasts
    // exactly N*TICK_DIV clocks regardless of where the free-running phase was.
    assign timer_clr = (state_next != state_reg) || timer_restart;

    // State and game bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            idx_reg        <= '0;
            score_reg      <= '0;
            game_over_reg  <= 1'b0;
            last_press_reg <= NULL_COLOR;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            score_reg      <= score_next;
            game_over_reg  <= game_over_next;
            last_press_reg <= last_press_next;
        end
    end

    // Tick divider and per-state tick timer.
    always_ff @(posedge clk) begin
        if (!reset || timer_clr) begin
            div_reg   <= '0;
            timer_reg <= '0;
        end else if (tick) begin
            div_reg   <= '0;
            timer_reg <= timer_reg + 1'b1;
        end else begin
            div_reg   <= div_reg + 1'b1;
        end
    end

    // Pattern bank with registered read addressed by the next index, so the
    // colour for idx_reg is ready in the same cycle idx_reg takes its value.
    // A write to the address being fetched forwards the new colour.
    always_ff @(posedge clk) begin
        if (mem_we)
            pattern_mem[wr_addr] <= rnd;
        rd_data_reg <= (mem_we && (wr_addr == idx_next)) ? rnd : pattern_mem[idx_next];
    end

    // Next-state, bookkeeping updates and Moore-style outputs.
    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        idx_next        = idx_reg;
        score_next      = score_reg;
        game_over_next  = game_over_reg;
        last_press_next = last_press_reg;
        timer_restart   = 1'b0;
        mem_we          = 1'b0;
        disp_color      = NULL_COLOR;
        buzzer          = 1'b0;
        busy            = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_EXTEND;
                    score_next     = '0;
                    game_over_next = 1'b0;
                end
            end
            ST_EXTEND: begin
                mem_we     = 1'b1;
                len_next   = len_reg + 1'b1;
                idx_next   = '0;
                state_next = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                disp_color = {1'b0, rd_data_reg};
                if (show_done)
                    state_next = ST_SHOW_OFF;
            end
            ST_SHOW_OFF: begin
                if (gap_done) begin
                    if (idx_last) begin
                        idx_next        = '0;
                        last_press_next = NULL_COLOR;
                        state_next      = ST_WAIT_IN;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_SHOW_ON;
                    end
                end
            end
            ST_WAIT_IN: begin
                disp_color = last_press_reg;
                // A press takes priority over a timeout expiring in the same cycle.
                if (btn_valid) begin
                    if (btn_color == rd_data_reg) begin
                        last_press_next = {1'b0, btn_color};
                        if (idx_last) begin
                            state_next = ST_CHECK;
                        end else begin
                            idx_next      = idx_reg + 1'b1;
                            timer_restart = 1'b1;
                        end
                    end else begin
                        state_next = ST_FAIL;
                    end
                end else if (timeout_done) begin
                    state_next = ST_FAIL;
                end
            end
            ST_CHECK: begin
                score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                if (len_reg == LEN_MAX) begin
                    state_next     = ST_WIN;
                    game_over_next = 1'b1;
                end else begin
                    state_next = ST_EXTEND;
                end
            end
            ST_FAIL: begin
                buzzer = 1'b1;
                if (buzz_done) begin
                    game_over_next = 1'b1;
                    len_next       = '0;
                    state_next     = ST_IDLE;
                end
            end
            ST_WIN: begin
                len_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign score     = score_reg;
    assign game_over = game_over_reg;

endmodule
